// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: drives the imem req/ack handshake from the PC and hands one instruction per cycle to decode.
// Latency: imem ack to if_valid is one cycle. imem_req/imem_addr are decoded from state; every other output is registered.
// Backpressure: stall holds if_*; one fetch that completes under stall parks in a one-entry skid, and requests pause until it drains.
module fetch_ctrl #(
  parameter int unsigned       WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = '0,
  parameter logic [31:0]       NOP      = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_target,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_pc,
  output logic [31:0]      if_instr,
  output logic [WIDTH-1:0] pc
);

  // IDLE: post-reset bubble. FETCH: request at pc. HOLD: skid full, decode stalled.
  // DRAIN: a redirect abandoned a pending request; keep its address until the ack arrives.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);
  localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] drain_addr_q, drain_addr_d;
  logic [WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic [31:0]      skid_instr_q, skid_instr_d;
  logic             if_valid_q, if_valid_d;
  logic [WIDTH-1:0] if_pc_q, if_pc_d;
  logic [31:0]      if_instr_q, if_instr_d;

  logic [WIDTH-1:0] target_al;
  logic [WIDTH-1:0] pc_inc;

  // Word-align the redirect target; pc+4 wraps naturally at the top of the address space.
  assign target_al = redirect_target & ALIGN_MASK;
  assign pc_inc    = pc_q + PC_STEP;

  // Next-state and next-output computation for the fetch sequencer.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    if_valid_d   = if_valid_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;

    unique case (state_q)
      S_IDLE: begin
        // One bubble before the first request; a redirect seen here still steers the PC.
        state_d = S_FETCH;
        if (redirect) begin
          pc_d = target_al;
        end
      end

      S_FETCH: begin
        if (redirect) begin
          // Flush whatever decode holds; a redirect outranks a returning fetch.
          pc_d       = target_al;
          if_valid_d = 1'b0;
          if_instr_d = NOP;
          if (!imem_ack) begin
            // Request still outstanding: keep its address on the bus until it completes.
            drain_addr_d = pc_q;
            state_d      = S_DRAIN;
          end
        end else if (imem_ack) begin
          pc_d = pc_inc;
          if (!stall || !if_valid_q) begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_instr_d = imem_rdata;
          end else begin
            // Decode is stalled on a valid instruction: park the new one.
            skid_pc_d    = pc_q;
            skid_instr_d = imem_rdata;
            state_d      = S_HOLD;
          end
        end else if (!stall) begin
          // Current instruction consumed and nothing new arrived.
          if_valid_d = 1'b0;
          if_instr_d = NOP;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          // Both the presented and parked instructions are on the wrong path.
          if_valid_d = 1'b0;
          if_instr_d = NOP;
          pc_d       = target_al;
          state_d    = S_FETCH;
        end else if (!stall) begin
          if_valid_d = 1'b1;
          if_pc_d    = skid_pc_q;
          if_instr_d = skid_instr_q;
          state_d    = S_FETCH;
        end
      end

      S_DRAIN: begin
        // Nothing valid reaches decode while the stale fetch completes.
        if_valid_d = 1'b0;
        if_instr_d = NOP;
        if (redirect) begin
          pc_d = target_al;
        end
        if (imem_ack) begin
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; synchronous reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      if_valid_q   <= 1'b0;
      if_pc_q      <= '0;
      if_instr_q   <= NOP;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
    end
  end

  assign imem_req  = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign imem_addr = (state_q == S_DRAIN) ? drain_addr_q : pc_q;

  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;
  assign pc        = pc_q;

`ifndef SYNTHESIS
  // A pending request must not move its address until acknowledged.
  a_addr_stable: assert property (@(posedge clk) disable iff (rst)
    (imem_req && !imem_ack) |=> (imem_req && imem_addr == $past(imem_addr)));

  // Decode never sees a stale word while nothing is valid.
  a_nop_when_idle: assert property (@(posedge clk) disable iff (rst)
    !if_valid |-> (if_instr == NOP));

  // The PC is always word-aligned.
  a_pc_aligned: assert property (@(posedge clk) disable iff (rst)
    (pc[1:0] == 2'b00));
`endif

endmodule
